// File: rtl/sprite_vram_writer.sv
// -----------------------------------------------------------------------------
// sprite_vram_writer
//
// Write side of a double-buffered sprite VRAM. A pixel stream (8-bit palette
// indices) arrives over a valid/ready handshake and is written into the back
// bank of the sram. Once a whole sprite is loaded, the writer waits for the
// start of the next vertical sync pulse and then swaps banks. The display
// therefore never shows a half-loaded sprite.
//
// Ports:
//   clk           system clock (same domain as the SVGA sync generator)
//   reset         asynchronous, active-low reset
//   s_valid       pixel beat valid
//   s_ready       writer can accept a beat (registered, depends only on state)
//   s_first       beat is pixel 0 of a sprite
//   s_data        palette index
//   vsync         vertical sync, synchronous to clk
//   o_addr        sram address {back_bank, pixel_index}
//   o_write       sram write enable (one cycle after each accepted beat)
//   o_data        sram write data
//   bank_sel      front (displayed) bank; the display uses it as its address MSB
//   o_busy        a sprite load or swap is pending
//   o_frame_done  one-cycle pulse on bank swap
//   o_err         sticky protocol error (stray non-first beat, or restart)
// -----------------------------------------------------------------------------
module sprite_vram_writer #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 1024,
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_first,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  vsync,
  output logic [ADDR_WIDTH:0]   o_addr,
  output logic                  o_write,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  bank_sel,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic                  o_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT_VS = 2'd2,
    ST_SWAP    = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ZERO   = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic                  VS_ACT_LVL = (VS_ACTIVE_LOW == 0) ? 1'b1 : 1'b0;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   count_q, count_d;
  logic                    bank_q, bank_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    ready_q, ready_d;
  logic                    busy_q, busy_d;
  logic                    fd_q, fd_d;
  logic                    err_q, err_d;
  logic                    vs_prev_q;

  logic                    xfer;
  logic                    vs_act;
  logic                    vs_start;
  logic                    load_beat;
  logic [ADDR_WIDTH-1:0]   pix_idx;
  logic [ADDR_WIDTH-1:0]   pix_next;
  logic                    pix_last;

  assign xfer     = s_valid & ready_q;
  assign vs_act   = (vsync == VS_ACT_LVL);
  assign vs_start = vs_act & ~vs_prev_q;
  // A beat is written when it starts a sprite, or continues one already loading.
  assign load_beat = xfer & (s_first | (state_q == ST_LOAD));
  // s_first always (re)starts at pixel 0, whatever the current count is.
  assign pix_idx  = s_first ? IDX_ZERO : count_q;
  assign pix_next = pix_idx + IDX_ONE;
  assign pix_last = (pix_idx == LAST_IDX);

  // Next-state and registered-output logic of the load / swap FSM.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    bank_d  = bank_q;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    busy_d  = busy_q;
    fd_d    = 1'b0;
    err_d   = err_q;

    case (state_q)
      ST_IDLE, ST_LOAD: begin
        if (load_beat) begin
          wr_d   = 1'b1;
          addr_d = {~bank_q, pix_idx};
          data_d = s_data;
          busy_d = 1'b1;
          if (s_first && (state_q == ST_LOAD)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          // The final pixel closes the sprite; no beat past DEPTH is taken.
          if (pix_last) begin
            count_d = IDX_ZERO;
            state_d = ST_WAIT_VS;
          end else begin
            count_d = pix_next;
            state_d = ST_LOAD;
          end
        end else if (xfer) begin
          // Non-first beat while idle: consumed and dropped.
          err_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_WAIT_VS: begin
        // Only a fresh pulse start counts; entering mid-pulse waits for the next.
        if (vs_start) begin
          state_d = ST_SWAP;
        end else begin
          state_d = state_q;
        end
      end
      ST_SWAP: begin
        bank_d  = ~bank_q;
        fd_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= IDX_ZERO;
      bank_q    <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= {(ADDR_WIDTH+1){1'b0}};
      data_q    <= {DATA_WIDTH{1'b0}};
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bank_q    <= bank_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
      vs_prev_q <= vs_act;
    end
  end

  assign s_ready      = ready_q;
  assign o_addr       = addr_q;
  assign o_write      = wr_q;
  assign o_data       = data_q;
  assign bank_sel     = bank_q;
  assign o_busy       = busy_q;
  assign o_frame_done = fd_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_sprite_vram_writer.sv
module tb_sprite_vram_writer;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic        s_first;
  logic [7:0]  s_data;
  logic        vsync;
  logic [10:0] o_addr;
  logic        o_write;
  logic [7:0]  o_data;
  logic        bank_sel;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_err;

  int          total;
  int          bad;
  int          fd_count;
  logic [18:0] exp_q[$];

  typedef struct {
    logic        v;
    logic        f;
    logic [7:0]  d;
    logic        rdy;
    logic        err;
    logic        busy;
    logic        wr;
    logic [10:0] addr;
    logic [7:0]  dat;
  } row_t;

  row_t tbl[7];

  sprite_vram_writer #(
    .ADDR_WIDTH(10), .DATA_WIDTH(8), .DEPTH(1024), .VS_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_first(s_first), .s_data(s_data), .vsync(vsync), .o_addr(o_addr),
    .o_write(o_write), .o_data(o_data), .bank_sel(bank_sel), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: through the active edge, return on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard side: every write the DUT makes must match the queue head.
  task automatic monitor();
    logic        fd_prev;
    logic [18:0] e;
    fd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_write === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL write_unexpected: got addr=%0h data=%0h expected no write", o_addr, o_data);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr_data", {13'd0, o_addr, o_data}, {13'd0, e});
        end
      end
      if (o_frame_done === 1'b1) begin
        fd_count++;
        chk("frame_done_one_cycle", {31'd0, fd_prev}, 32'd0);
      end
      fd_prev = o_frame_done;
    end
  endtask

  task automatic send_beat(input logic first, input logic [7:0] d, input logic [10:0] a);
    logic done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_first = first;
    s_data  = d;
    for (int k = 0; k < 20 && !done; k++) begin
      if (s_ready === 1'b1) begin
        exp_q.push_back({a, d});
        done = 1'b1;
      end
      tick();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL beat_accept: got no s_ready expected acceptance of addr %0h", a);
    end
  endtask

  // Beats from..to-1 of a sprite; beat 0 carries s_first.
  task automatic load_range(input logic bank_b, input int from, input int to, input int doff);
    for (int i = from; i < to; i++) begin
      send_beat(i == 0, 8'(i + doff), {bank_b, 10'(i)});
    end
  endtask

  task automatic drop_valid();
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  // Pulse-start on vsync must produce SWAP then the toggled bank one edge later.
  task automatic vs_swap(input logic new_bank);
    vsync = 1'b0;
    tick();
    chk("swap_fd_early", {31'd0, o_frame_done}, 32'd0);
    chk("swap_bank_early", {31'd0, bank_sel}, {31'd0, ~new_bank});
    tick();
    chk("swap_fd", {31'd0, o_frame_done}, 32'd1);
    chk("swap_bank", {31'd0, bank_sel}, {31'd0, new_bank});
    chk("swap_busy", {31'd0, o_busy}, 32'd0);
    tick();
    chk("swap_fd_clear", {31'd0, o_frame_done}, 32'd0);
    chk("swap_ready", {31'd0, s_ready}, 32'd1);
    repeat (3) tick();
    vsync = 1'b1;
    tick();
  endtask

  initial begin
    int fd_before;
    total    = 0;
    bad      = 0;
    fd_count = 0;
    reset    = 1'b0;
    s_valid  = 1'b0;
    s_first  = 1'b0;
    s_data   = 8'h00;
    vsync    = 1'b1;

    //            v     f     d      rdy   err   busy  wr    addr     dat
    tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 11'h000, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 11'h000, 8'h00};
    tbl[3] = '{1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1, 11'h400, 8'h5A};
    tbl[4] = '{1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 11'h401, 8'h11};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 11'h401, 8'h11};
    tbl[6] = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 11'h402, 8'h22};

    fork
      monitor();
    join_none

    // Reset state.
    @(negedge clk);
    tick();
    chk("rst_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_bank", {31'd0, bank_sel}, 32'd0);
    chk("rst_write", {31'd0, o_write}, 32'd0);
    chk("rst_addr", {21'd0, o_addr}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_err", {31'd0, o_err}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_ready", {31'd0, s_ready}, 32'd1);
    chk("rel_bank", {31'd0, bank_sel}, 32'd0);
    chk("rel_err", {31'd0, o_err}, 32'd0);

    // Full sprite into bank 1, then beats past DEPTH must be refused.
    load_range(1'b1, 0, 1024, 0);
    chk("full_ready_drop", {31'd0, s_ready}, 32'd0);
    chk("full_busy", {31'd0, o_busy}, 32'd1);
    s_first = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("beyond_depth_ready", {31'd0, s_ready}, 32'd0);
    end
    drop_valid();
    chk("full_bank_hold", {31'd0, bank_sel}, 32'd0);
    vs_swap(1'b1);

    // Second sprite into bank 0 while vsync is already low: needs a new pulse.
    vsync = 1'b0;
    tick();
    load_range(1'b0, 0, 1024, 7);
    drop_valid();
    fd_before = fd_count;
    repeat (6) tick();
    chk("inpulse_no_swap_bank", {31'd0, bank_sel}, 32'd1);
    chk("inpulse_no_fd", fd_count, fd_before);
    vsync = 1'b1;
    repeat (3) tick();
    vs_swap(1'b0);
    chk("no_err_so_far", {31'd0, o_err}, 32'd0);

    // Restart at pixel 500; swap only after 1024 beats from the restart.
    load_range(1'b1, 0, 500, 0);
    chk("pre_restart_err", {31'd0, o_err}, 32'd0);
    load_range(1'b1, 0, 1023, 8'h33);
    chk("restart_err", {31'd0, o_err}, 32'd1);
    chk("restart_ready_1023", {31'd0, s_ready}, 32'd1);
    load_range(1'b1, 1023, 1024, 8'h33);
    drop_valid();
    chk("restart_ready_end", {31'd0, s_ready}, 32'd0);
    vs_swap(1'b1);
    chk("err_sticky", {31'd0, o_err}, 32'd1);

    // Reset clears everything; then the table covers IDLE stray beats.
    apply_reset();
    chk("rst2_bank", {31'd0, bank_sel}, 32'd0);
    for (int r = 0; r < 7; r++) begin
      s_valid = tbl[r].v;
      s_first = tbl[r].f;
      s_data  = tbl[r].d;
      if (tbl[r].wr) exp_q.push_back({tbl[r].addr, tbl[r].dat});
      tick();
      chk($sformatf("tbl%0d_ready", r), {31'd0, s_ready}, {31'd0, tbl[r].rdy});
      chk($sformatf("tbl%0d_err", r), {31'd0, o_err}, {31'd0, tbl[r].err});
      chk($sformatf("tbl%0d_busy", r), {31'd0, o_busy}, {31'd0, tbl[r].busy});
      chk($sformatf("tbl%0d_write", r), {31'd0, o_write}, {31'd0, tbl[r].wr});
      chk($sformatf("tbl%0d_addr", r), {21'd0, o_addr}, {21'd0, tbl[r].addr});
      chk($sformatf("tbl%0d_data", r), {24'd0, o_data}, {24'd0, tbl[r].dat});
    end
    load_range(1'b1, 3, 1024, 0);
    drop_valid();
    vs_swap(1'b1);

    // Load into bank 0, then reset while waiting for vsync.
    load_range(1'b0, 0, 1024, 5);
    drop_valid();
    tick();
    fd_before = fd_count;
    #2;
    reset = 1'b0;
    #1;
    chk("wvs_rst_bank", {31'd0, bank_sel}, 32'd0);
    chk("wvs_rst_ready", {31'd0, s_ready}, 32'd0);
    chk("wvs_rst_fd", {31'd0, o_frame_done}, 32'd0);
    chk("wvs_rst_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    vsync = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (4) tick();
    vsync = 1'b1;
    tick();
    chk("wvs_rst_no_fd", fd_count, fd_before);
    chk("wvs_rst_bank_after", {31'd0, bank_sel}, 32'd0);
    chk("wvs_rst_ready_after", {31'd0, s_ready}, 32'd1);

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("swap_count", fd_count, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_vram_writer.md
Name: sprite_vram_writer

Overview:
- Write side of the sprite VRAM. The display path reads one 32x32 sprite of 8-bit palette indices from this VRAM.
- Accepts a pixel stream from the game/CPU logic over a valid/ready handshake and writes it into the back bank of a double-buffered sram.
- Swaps banks at the start of the next vertical sync pulse, so the display path never shows a half-loaded sprite.
- Sits between the sprite source and the `sram` instance. The display path uses `bank_sel` as the MSB of its read address.

Parameters:
- ADDR_WIDTH, 10, address bits per bank; the sram address is ADDR_WIDTH+1 bits.
- DATA_WIDTH, 8, bits per pixel (palette index).
- DEPTH, 1024, pixels per sprite (SPRITE_WIDTH*SPRITE_HEIGHT); must be <= 2**ADDR_WIDTH.
- VS_ACTIVE_LOW, 1, 1 = vsync pulse is low; 0 = vsync pulse is high.

Ports:
- clk  in  1  system clock (50 MHz); same domain as SVGA_sync.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  pixel beat valid.
- s_ready  out  1  writer can accept a beat.
- s_first  in  1  beat is pixel 0 of a sprite.
- s_data  in  DATA_WIDTH  palette index.
- vsync  in  1  vertical sync from SVGA_sync, synchronous to clk.
- o_addr  out  ADDR_WIDTH+1  sram address, {back_bank, pixel_index}.
- o_write  out  1  sram write enable.
- o_data  out  DATA_WIDTH  sram write data.
- bank_sel  out  1  front (displayed) bank.
- o_busy  out  1  a sprite load or swap is pending.
- o_frame_done  out  1  one-cycle pulse on bank swap.
- o_err  out  1  sticky protocol error flag.

Behaviour:
- Reset values (reset low, applied immediately):
  - State IDLE, pixel count 0.
  - bank_sel=0, o_write=0, o_addr=0, o_data=0.
  - s_ready=0, o_busy=0, o_frame_done=0, o_err=0.
  - Internal vsync history register = inactive level.
- Reset mid-load abandons the load. The back bank keeps partial data, which is harmless because it is not displayed.
- A transfer occurs on a clk edge where s_valid && s_ready.
- Write latency is 1 cycle. On the cycle after a transfer: o_write=1, o_addr={~bank_sel, count}, o_data=the beat's data. At all other times o_write=0; o_addr and o_data hold their last values.
- s_ready is registered and depends only on state: 1 in IDLE and LOAD, 0 in WAIT_VS, SWAP and reset.
- State IDLE:
  - Transfer with s_first=1: write pixel 0, count<=1, go to LOAD, o_busy<=1.
  - Transfer with s_first=0: beat is consumed and discarded, no write, o_err<=1.
- State LOAD:
  - Transfer with s_first=0: write at count, count<=count+1.
  - Transfer with s_first=1: restart. Write at 0, count<=1, o_err<=1.
  - When the transfer writes pixel DEPTH-1: count<=0, go to WAIT_VS, s_ready<=0 in the same edge. No beat is accepted beyond DEPTH.
  - No timeout; the load waits indefinitely for beats.
- State WAIT_VS:
  - vs_act = (vsync == !VS_ACTIVE_LOW). vs_prev is vs_act registered.
  - On vs_act && !vs_prev (pulse start): go to SWAP.
  - If already inside a pulse on entry, wait for the next pulse start.
- State SWAP (1 cycle): bank_sel<=~bank_sel, o_frame_done<=1 (cleared next cycle), o_busy<=0, go to IDLE.
- bank_sel changes only in SWAP. Writes always target ~bank_sel, so the front bank is never written.
- The pulse-start edge counts only in WAIT_VS. Edges seen in other states are ignored.
- o_err clears only on reset.
- Counter is ADDR_WIDTH bits, with an explicit compare to DEPTH-1. No wrap beyond DEPTH.

Test Plan:
1. Reset release with s_valid=0 → s_ready=1 after 1 cycle, bank_sel=0, o_write=0, o_err=0.
2. Stream 1024 beats with data=i[7:0], s_first on beat 0, s_valid held 1:
   - o_write pulses with o_addr=0x400+i, o_data=i.
   - s_ready drops after beat 1023; beat 1024 is not accepted.
   - On the next vsync falling edge (VS_ACTIVE_LOW=1): bank_sel=1 and a one-cycle o_frame_done.
3. Second sprite after the swap → writes go to o_addr 0x000..0x3FF; bank_sel returns to 0 at the next vsync pulse start.
4. Beat with s_first=0 in IDLE → no o_write, o_err=1, state stays IDLE. A later s_first beat loads normally.
5. s_first reasserted at pixel 500 → write at o_addr 0x400 with the new data, o_err=1. Swap occurs only after 1024 beats counted from the restart.
6. Load completes while vsync is low → no swap until vsync rises and falls again. Reset asserted in WAIT_VS → bank_sel=0, s_ready=0 immediately, no o_frame_done.
